// File: rtl/dut_bus_arbiter_if.sv
// Shared downstream bus: registered transaction fields plus the freeze input.
interface dut_if (
    input logic clk
);
    logic [3:0] cmd;
    logic [3:0] adr;
    logic [3:0] data;
    logic       bus_valid;
    logic       bus_hold;

    // Arbiter side drives the transaction and obeys the freeze.
    modport master (
        input  bus_hold,
        output cmd,
        output adr,
        output data,
        output bus_valid
    );

    // Downstream side consumes the transaction and may freeze the arbiter.
    modport slave (
        input  clk,
        input  cmd,
        input  adr,
        input  data,
        input  bus_valid,
        output bus_hold
    );
endinterface

// File: rtl/dut_bus_arbiter.sv
// Round-robin arbiter with a per-owner grant quota. It drives the shared bus
// from registers and keeps a running count of accepted transfers.
// Handshake: a requester's transaction is accepted on a cycle where both
// req_valid[i] and req_ready[i] are high. req_ready is combinational from
// req_valid, bus_hold and arbiter state (never from payload), is at most
// one-hot, and is forced low during bus_hold or while rst_n is low.
module dut_bus_arbiter #(
    parameter int NREQ  = 4,
    parameter int QUOTA = 2,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [4*NREQ-1:0]   req_cmd,
    input  logic [4*NREQ-1:0]   req_adr,
    input  logic [4*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]     req_ready,
    dut_if.master               bus,
    output logic [2:0]          owner,
    output logic [CNT_W-1:0]    xfer_cnt,
    output logic                o_dbg_busy,
    output logic [3:0]          o_dbg_run
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [3:0]         r_run, w_run_nxt;
    logic [2:0]         r_ptr, w_ptr_nxt;
    logic [2:0]         r_owner, w_owner_nxt;
    logic [3:0]         r_cmd, w_cmd_nxt;
    logic [3:0]         r_adr, w_adr_nxt;
    logic [3:0]         r_data, w_data_nxt;
    logic               r_bus_valid, w_bus_valid_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;

    logic               w_owner_valid;
    logic               w_keep;
    logic               w_any;
    logic               w_grant;
    logic [2:0]         w_pick;
    logic [2:0]         w_winner;

    // Winner selection: keep the owner while its quota lasts, otherwise the
    // valid requester at the smallest rotational distance after ptr wins
    // (the previous owner sits at the largest distance, so it comes last).
    always_comb begin : sel
        int w_dist;
        int w_best;
        w_owner_valid = 1'b0;
        w_pick        = r_ptr;
        w_best        = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            if (3'(i) == r_owner) w_owner_valid = req_valid[i];
            w_dist = (i - int'(r_ptr) - 1 + 2 * NREQ) % NREQ;
            if (req_valid[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_pick = 3'(i);
            end
        end
        w_keep   = (r_state == ST_BUSY) && w_owner_valid && (r_run < 4'(QUOTA));
        w_winner = w_keep ? r_owner : w_pick;
        w_any    = |req_valid;
        w_grant  = rst_n && !bus.bus_hold && w_any;
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant && (3'(i) == w_winner)) req_ready[i] = 1'b1;
        end
    end

    // Next-state: load the winner's payload on a transfer, drain to NOP/IDLE
    // when nobody asks, and freeze everything while the bus is held.
    always_comb begin
        w_state_nxt     = r_state;
        w_run_nxt       = r_run;
        w_ptr_nxt       = r_ptr;
        w_owner_nxt     = r_owner;
        w_cmd_nxt       = r_cmd;
        w_adr_nxt       = r_adr;
        w_data_nxt      = r_data;
        w_bus_valid_nxt = r_bus_valid;
        w_cnt_nxt       = r_cnt;
        if (!bus.bus_hold) begin
            if (w_any) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (3'(i) == w_winner) begin
                        w_cmd_nxt  = req_cmd[4*i +: 4];
                        w_adr_nxt  = req_adr[4*i +: 4];
                        w_data_nxt = req_data[4*i +: 4];
                    end
                end
                w_bus_valid_nxt = 1'b1;
                w_cnt_nxt       = r_cnt + 1'b1;
                if (w_keep) begin
                    w_run_nxt = r_run + 4'd1;
                end else begin
                    // New owner, or the same owner re-granted after its quota.
                    w_run_nxt   = 4'd1;
                    w_ptr_nxt   = w_winner;
                    w_owner_nxt = w_winner;
                    w_state_nxt = ST_BUSY;
                end
            end else begin
                w_cmd_nxt       = 4'd0;
                w_adr_nxt       = 4'd0;
                w_data_nxt      = 4'd0;
                w_bus_valid_nxt = 1'b0;
                w_run_nxt       = 4'd0;
                w_state_nxt     = ST_IDLE;
            end
        end
    end

    // State and bus registers; ptr starts at the last index so req0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_run       <= 4'd0;
            r_ptr       <= 3'(NREQ - 1);
            r_owner     <= 3'd0;
            r_cmd       <= 4'd0;
            r_adr       <= 4'd0;
            r_data      <= 4'd0;
            r_bus_valid <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_run       <= w_run_nxt;
            r_ptr       <= w_ptr_nxt;
            r_owner     <= w_owner_nxt;
            r_cmd       <= w_cmd_nxt;
            r_adr       <= w_adr_nxt;
            r_data      <= w_data_nxt;
            r_bus_valid <= w_bus_valid_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    assign bus.cmd       = r_cmd;
    assign bus.adr       = r_adr;
    assign bus.data      = r_data;
    assign bus.bus_valid = r_bus_valid;
    assign owner         = r_owner;
    assign xfer_cnt      = r_cnt;
    assign o_dbg_busy    = (r_state == ST_BUSY);
    assign o_dbg_run     = r_run;

endmodule

// File: tb/tb_dut_bus_arbiter.sv
// Bench for dut_bus_arbiter: directed scenarios then random traffic, all
// checked against a queue-based round-robin reference model.
module tb_dut_bus_arbiter;

    localparam int NREQ  = 4;
    localparam int QUOTA = 2;
    localparam int CNT_W = 4;

    // Clock and DUT wiring
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [4*NREQ-1:0]   req_cmd, req_adr, req_data;
    logic [NREQ-1:0]     req_ready;
    logic [2:0]          owner;
    logic [CNT_W-1:0]    xfer_cnt;
    logic                o_dbg_busy;
    logic [3:0]          o_dbg_run;

    dut_if bus_if (.clk(clk));

    dut_bus_arbiter #(.NREQ(NREQ), .QUOTA(QUOTA), .CNT_W(CNT_W)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_cmd    (req_cmd),
        .req_adr    (req_adr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .bus        (bus_if.master),
        .owner      (owner),
        .xfer_cnt   (xfer_cnt),
        .o_dbg_busy (o_dbg_busy),
        .o_dbg_run  (o_dbg_run)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int         m_owner, m_ptr, m_run, m_cnt;
    bit         m_busy, m_bv;
    logic [3:0] m_cmd, m_adr, m_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = 0; m_ptr = NREQ - 1; m_run = 0; m_cnt = 0;
        m_busy = 0; m_bv = 0; m_cmd = 0; m_adr = 0; m_data = 0;
    endtask

    function automatic bit model_keeps(input logic [NREQ-1:0] v);
        return m_busy && v[m_owner] && (m_run < QUOTA);
    endfunction

    // Owner continues under quota; otherwise walk the rotation order after ptr.
    function automatic int model_pick(input logic [NREQ-1:0] v);
        int order[$];
        if (model_keeps(v)) return m_owner;
        for (int k = 1; k <= NREQ; k++) order.push_back((m_ptr + k) % NREQ);
        foreach (order[j]) if (v[order[j]]) return order[j];
        return -1;
    endfunction

    // Drive one cycle, check the grant before the edge and the bus after it.
    task automatic run_cycle(input logic [NREQ-1:0] v, input logic h,
                             input logic [4*NREQ-1:0] c, a, d);
        int              win;
        bit              kept;
        logic [NREQ-1:0] exp_rdy;
        @(negedge clk);
        req_valid = v; bus_if.bus_hold = h;
        req_cmd = c; req_adr = a; req_data = d;
        #1;
        kept = model_keeps(v);
        win  = h ? -1 : model_pick(v);
        exp_rdy = '0;
        if (win >= 0) exp_rdy[win] = 1'b1;
        chk("req_ready", req_ready, exp_rdy);
        @(posedge clk);
        if (!h) begin
            if (win >= 0) begin
                m_cmd = c[4*win +: 4]; m_adr = a[4*win +: 4]; m_data = d[4*win +: 4];
                m_bv = 1; m_cnt = (m_cnt + 1) % (1 << CNT_W);
                if (kept) m_run++;
                else begin m_run = 1; m_owner = win; m_ptr = win; m_busy = 1; end
            end else begin
                m_cmd = 0; m_adr = 0; m_data = 0; m_bv = 0; m_busy = 0; m_run = 0;
            end
        end
        #1;
        chk("cmd", bus_if.cmd, m_cmd);
        chk("adr", bus_if.adr, m_adr);
        chk("data", bus_if.data, m_data);
        chk("bus_valid", bus_if.bus_valid, m_bv);
        chk("owner", owner, m_owner);
        chk("xfer_cnt", xfer_cnt, m_cnt);
        chk("busy", o_dbg_busy, m_busy);
        chk("run", o_dbg_run, m_run);
    endtask

    task automatic cyc_rand(input logic [NREQ-1:0] v, input logic h);
        logic [4*NREQ-1:0] c, a, d;
        for (int i = 0; i < NREQ; i++) begin
            c[4*i +: 4] = 4'($urandom_range(1, 15));
            a[4*i +: 4] = 4'($urandom_range(0, 15));
            d[4*i +: 4] = 4'($urandom_range(0, 15));
        end
        run_cycle(v, h, c, a, d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_valid = '0; bus_if.bus_hold = 1'b0; rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int                exp_seq[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    logic [4*NREQ-1:0] st_c, st_a, st_d;

    initial begin
        // Power-on reset, with requests present to show req_ready is gated
        rst_n = 1'b1; req_valid = '1; bus_if.bus_hold = 1'b0;
        req_cmd = '0; req_adr = '0; req_data = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_cmd", bus_if.cmd, 0);
        chk("rst_bus_valid", bus_if.bus_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_owner", owner, 0);
        chk("rst_xfer_cnt", xfer_cnt, 0);
        chk("rst_busy", o_dbg_busy, 0);
        req_valid = '0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Single transfer
        st_c = '0; st_a = '0; st_d = '0;
        st_c[3:0] = 4'd3; st_a[3:0] = 4'd5; st_d[3:0] = 4'd9;
        run_cycle(4'b0001, 1'b0, st_c, st_a, st_d);
        chk("st_cmd", bus_if.cmd, 3);
        chk("st_adr", bus_if.adr, 5);
        chk("st_data", bus_if.data, 9);
        chk("st_valid", bus_if.bus_valid, 1);
        chk("st_cnt", xfer_cnt, 1);
        run_cycle(4'b0000, 1'b0, st_c, st_a, st_d);
        chk("st_idle_valid", bus_if.bus_valid, 0);
        chk("st_idle_cmd", bus_if.cmd, 0);

        // Full contention
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc_rand(4'b1111, 1'b0);
            chk("cont_owner", owner, exp_seq[i]);
            chk("cont_valid", bus_if.bus_valid, 1);
        end
        chk("cont_cnt", xfer_cnt, 10);

        // Early drop by the owner
        do_reset();
        cyc_rand(4'b0001, 1'b0); chk("drop_o0", owner, 0);
        cyc_rand(4'b0100, 1'b0); chk("drop_o1", owner, 2); chk("drop_r1", o_dbg_run, 1);
        cyc_rand(4'b0101, 1'b0); chk("drop_o2", owner, 2); chk("drop_r2", o_dbg_run, 2);
        cyc_rand(4'b0101, 1'b0); chk("drop_o3", owner, 0);

        // Hold while req1 has run=1
        do_reset();
        repeat (3) cyc_rand(4'b1111, 1'b0);
        chk("hold_pre_owner", owner, 1);
        repeat (3) begin
            cyc_rand(4'b1111, 1'b1);
            chk("hold_owner", owner, 1);
            chk("hold_run", o_dbg_run, 1);
        end
        cyc_rand(4'b1111, 1'b0); chk("hold_rel_o1", owner, 1);
        cyc_rand(4'b1111, 1'b0); chk("hold_rel_o2", owner, 2);

        // Reset in the middle of a burst, between clock edges
        do_reset();
        repeat (3) cyc_rand(4'b1111, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_cmd", bus_if.cmd, 0);
        chk("mid_valid", bus_if.bus_valid, 0);
        chk("mid_ready", req_ready, 0);
        chk("mid_owner", owner, 0);
        chk("mid_cnt", xfer_cnt, 0);
        req_valid = '0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc_rand(4'b1111, 1'b0);
        chk("mid_first_owner", owner, 0);
        chk("mid_first_cnt", xfer_cnt, 1);

        // Counter wrap
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            cyc_rand(4'b1111, 1'b0);
            if (i == 15) chk("wrap_15", xfer_cnt, 15);
            if (i == 16) chk("wrap_16", xfer_cnt, 0);
            if (i == 17) chk("wrap_17", xfer_cnt, 1);
        end

        // Random traffic with occasional hold
        do_reset();
        for (int i = 0; i < 120; i++) begin
            cyc_rand(4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
